// File: rtl/mem_pkg.sv
// Shared definitions for the ram512x8 requester: opcodes, FSM states, access sizes
// and the alignment rule that keeps every access inside one aligned container.
package mem_pkg;

    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_SD  = 6'b111101;
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_LD  = 6'b110101;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PULSE,
        RECOVER,
        RESP
    } state_e;

    typedef enum logic [1:0] {
        BYTE,
        HALF,
        WORD,
        DOUBLE
    } size_e;

    // Natural alignment also guarantees no access can run past the last byte.
    function automatic logic is_aligned(input size_e sz, input logic [2:0] addr_lo);
        logic ok;
        case (sz)
            BYTE:    ok = 1'b1;
            HALF:    ok = (addr_lo[0] == 1'b0);
            WORD:    ok = (addr_lo[1:0] == 2'b00);
            default: ok = (addr_lo == 3'b000);
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_op_decode.sv
// Combinational opcode classifier: legality, direction, double-word flag and
// alignment check of the low address bits.
module mem_op_decode
    import mem_pkg::*;
(
    input  logic [5:0] i_op,
    input  logic [2:0] i_addr_lo,
    output logic       o_legal,
    output logic       o_is_store,
    output logic       o_is_double,
    output logic       o_aligned
);

    size_e w_size;

    always_comb begin
        o_legal    = 1'b1;
        o_is_store = 1'b0;
        w_size     = BYTE;
        case (i_op)
            OP_SB:  begin o_is_store = 1'b1; w_size = BYTE;   end
            OP_SH:  begin o_is_store = 1'b1; w_size = HALF;   end
            OP_SW:  begin o_is_store = 1'b1; w_size = WORD;   end
            OP_SD:  begin o_is_store = 1'b1; w_size = DOUBLE; end
            OP_LB:  w_size = BYTE;
            OP_LBU: w_size = BYTE;
            OP_LH:  w_size = HALF;
            OP_LHU: w_size = HALF;
            OP_LW:  w_size = WORD;
            OP_LD:  w_size = DOUBLE;
            default: o_legal = 1'b0;
        endcase
    end

    assign o_is_double = (w_size == DOUBLE);
    assign o_aligned   = is_aligned(w_size, i_addr_lo);

endmodule

// File: rtl/mem_access_initiator.sv
// Requester-side controller for ram512x8: validates one CPU load/store, pulses the
// RAM Enable once (or twice for double words) and returns data or an error.
module mem_access_initiator
    import mem_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int ADDR_W  = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [5:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [63:0]       req_wdata,
    output logic              rsp_valid,
    output logic [63:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              ram_enable,
    output logic [ADDR_W-1:0] ram_address,
    output logic [31:0]       ram_datain,
    output logic [5:0]        ram_opcode,
    input  logic [31:0]       ram_dataout,
    input  logic              ram_done,
    input  logic              ram_almostdone
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e            r_state, r_state_next;
    logic              r_phase, r_phase_next;
    logic              r_err, r_err_next;
    logic              r_is_double, r_is_double_next;
    logic [CNT_W-1:0]  r_cnt, r_cnt_next;
    logic [31:0]       r_wdata_lo, r_wdata_lo_next;
    logic [63:0]       r_data, r_data_next;
    logic              r_ram_enable, r_ram_enable_next;
    logic [ADDR_W-1:0] r_ram_address, r_ram_address_next;
    logic [31:0]       r_ram_datain, r_ram_datain_next;
    logic [5:0]        r_ram_opcode, r_ram_opcode_next;
    logic              r_rsp_valid, r_rsp_valid_next;
    logic [63:0]       r_rsp_rdata, r_rsp_rdata_next;
    logic              r_rsp_err, r_rsp_err_next;

    logic w_legal, w_is_store, w_is_double, w_aligned;

    mem_op_decode u_decode (
        .i_op        (req_op),
        .i_addr_lo   (req_addr[2:0]),
        .o_legal     (w_legal),
        .o_is_store  (w_is_store),
        .o_is_double (w_is_double),
        .o_aligned   (w_aligned)
    );

    always_comb begin
        r_state_next       = r_state;
        r_phase_next       = r_phase;
        r_err_next         = r_err;
        r_is_double_next   = r_is_double;
        r_cnt_next         = r_cnt;
        r_wdata_lo_next    = r_wdata_lo;
        r_data_next        = r_data;
        r_ram_address_next = r_ram_address;
        r_ram_datain_next  = r_ram_datain;
        r_ram_opcode_next  = r_ram_opcode;
        r_rsp_valid_next   = 1'b0;
        r_rsp_rdata_next   = r_rsp_rdata;
        r_rsp_err_next     = r_rsp_err;

        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    r_is_double_next = w_is_double;
                    r_wdata_lo_next  = req_wdata[31:0];
                    r_data_next      = '0;
                    if (!(w_legal && w_aligned)) begin
                        r_err_next   = 1'b1;
                        r_state_next = RESP;
                    end else begin
                        r_ram_address_next = req_addr;
                        r_ram_opcode_next  = req_op;
                        r_ram_datain_next  = (w_is_double && w_is_store) ?
                                             req_wdata[63:32] : req_wdata[31:0];
                        r_state_next       = SETUP;
                    end
                end
            end
            SETUP: begin
                // almostdone here means the RAM was abandoned mid double sequence.
                if (r_is_double && ram_almostdone) begin
                    r_err_next   = 1'b1;
                    r_state_next = RESP;
                end else begin
                    r_cnt_next   = '0;
                    r_state_next = PULSE;
                end
            end
            PULSE: begin
                if (ram_done) begin
                    if (r_is_double && !r_phase)
                        r_data_next[63:32] = ram_dataout;
                    else
                        r_data_next[31:0] = ram_dataout;
                    r_state_next = RECOVER;
                end else if (r_cnt == CNT_LAST) begin
                    r_err_next   = 1'b1;
                    r_state_next = RECOVER;
                end else begin
                    r_cnt_next = r_cnt + 1'b1;
                end
            end
            RECOVER: begin
                if (r_is_double && !r_phase && !r_err) begin
                    if (ram_almostdone) begin
                        // Second word: RAM adds the +4 offset, so only the data changes.
                        r_phase_next      = 1'b1;
                        r_ram_datain_next = r_wdata_lo;
                        r_cnt_next        = '0;
                        r_state_next      = PULSE;
                    end else begin
                        r_err_next   = 1'b1;
                        r_state_next = RESP;
                    end
                end else begin
                    r_state_next = RESP;
                end
            end
            RESP: begin
                r_rsp_valid_next = 1'b1;
                r_rsp_rdata_next = r_data;
                r_rsp_err_next   = r_err;
                r_phase_next     = 1'b0;
                r_err_next       = 1'b0;
                r_state_next     = IDLE;
            end
            default: r_state_next = IDLE;
        endcase

        r_ram_enable_next = (r_state_next == PULSE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_phase       <= 1'b0;
            r_err         <= 1'b0;
            r_is_double   <= 1'b0;
            r_cnt         <= '0;
            r_wdata_lo    <= '0;
            r_data        <= '0;
            r_ram_enable  <= 1'b0;
            r_ram_address <= '0;
            r_ram_datain  <= '0;
            r_ram_opcode  <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
        end else begin
            r_state       <= r_state_next;
            r_phase       <= r_phase_next;
            r_err         <= r_err_next;
            r_is_double   <= r_is_double_next;
            r_cnt         <= r_cnt_next;
            r_wdata_lo    <= r_wdata_lo_next;
            r_data        <= r_data_next;
            r_ram_enable  <= r_ram_enable_next;
            r_ram_address <= r_ram_address_next;
            r_ram_datain  <= r_ram_datain_next;
            r_ram_opcode  <= r_ram_opcode_next;
            r_rsp_valid   <= r_rsp_valid_next;
            r_rsp_rdata   <= r_rsp_rdata_next;
            r_rsp_err     <= r_rsp_err_next;
        end
    end

    assign req_ready   = (r_state == IDLE);
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_err     = r_rsp_err;
    assign ram_enable  = r_ram_enable;
    assign ram_address = r_ram_address;
    assign ram_datain  = r_ram_datain;
    assign ram_opcode  = r_ram_opcode;

endmodule

// File: tb/tb_mem_access_initiator.sv
// Scoreboard bench for mem_access_initiator with a behavioural big-endian ram512x8.
module tb_mem_access_initiator;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [5:0]  req_op = '0;
    logic [8:0]  req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic        rsp_valid;
    logic [63:0] rsp_rdata;
    logic        rsp_err;
    logic        ram_enable;
    logic [8:0]  ram_address;
    logic [31:0] ram_datain;
    logic [5:0]  ram_opcode;
    logic [31:0] ram_dataout;
    logic        ram_done;
    logic        ram_almostdone;

    mem_access_initiator #(.TIMEOUT(16), .ADDR_W(9)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .ram_enable(ram_enable), .ram_address(ram_address), .ram_datain(ram_datain),
        .ram_opcode(ram_opcode), .ram_dataout(ram_dataout), .ram_done(ram_done),
        .ram_almostdone(ram_almostdone)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: answers in the same cycle Enable is high unless stubbed.
    logic [7:0] mem [512];
    logic       seq = 1'b0;
    logic       ram_clr = 1'b1;
    logic       stub_no_done = 1'b0;

    assign ram_done       = ram_enable & ~stub_no_done;
    assign ram_almostdone = seq;

    function automatic logic [31:0] rd_word(input logic [8:0] b);
        return {mem[b], mem[b + 9'd1], mem[b + 9'd2], mem[b + 9'd3]};
    endfunction

    always_comb begin
        logic [8:0] a;
        a = ram_address;
        ram_dataout = 32'h0;
        case (ram_opcode)
            OP_LB:  ram_dataout = {{24{mem[a][7]}}, mem[a]};
            OP_LBU: ram_dataout = {24'h0, mem[a]};
            OP_LH:  ram_dataout = {{16{mem[a][7]}}, mem[a], mem[a + 9'd1]};
            OP_LHU: ram_dataout = {16'h0, mem[a], mem[a + 9'd1]};
            OP_LW:  ram_dataout = rd_word(a);
            OP_LD:  ram_dataout = rd_word(a + (seq ? 9'd4 : 9'd0));
            default: ram_dataout = 32'h0;
        endcase
    end

    always @(posedge clk) begin
        logic [8:0] b;
        b = ram_address + (seq ? 9'd4 : 9'd0);
        if (ram_clr) begin
            for (int i = 0; i < 512; i++) mem[i] <= 8'h00;
            seq <= 1'b0;
        end else if (ram_enable && ram_done) begin
            case (ram_opcode)
                OP_SB: mem[ram_address] <= ram_datain[7:0];
                OP_SH: begin
                    mem[ram_address]        <= ram_datain[15:8];
                    mem[ram_address + 9'd1] <= ram_datain[7:0];
                end
                OP_SW, OP_SD: begin
                    mem[b]        <= ram_datain[31:24];
                    mem[b + 9'd1] <= ram_datain[23:16];
                    mem[b + 9'd2] <= ram_datain[15:8];
                    mem[b + 9'd3] <= ram_datain[7:0];
                end
                default: ;
            endcase
            if (ram_opcode == OP_SD || ram_opcode == OP_LD) seq <= ~seq;
        end
    end

    // Bookkeeping observed from the bench side.
    int cyc = 0;
    int pulse_cnt = 0;
    int en_cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge ram_enable) pulse_cnt <= pulse_cnt + 1;
    always @(negedge clk) if (ram_enable) en_cyc <= en_cyc + 1;

    typedef struct {
        logic [63:0] rdata;
        logic        err;
        int          lat;
        int          acc;
        string       name;
    } exp_t;
    exp_t sb[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // Monitor: every response pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (rsp_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.name, "_err"}, {63'd0, rsp_err}, {63'd0, e.err});
                if (!e.err) chk({e.name, "_rdata"}, rsp_rdata, e.rdata);
                chk({e.name, "_latency"}, 64'(cyc - e.acc), 64'(e.lat));
            end
        end
    end

    task automatic issue(input string name, input logic [5:0] op, input logic [8:0] addr,
                         input logic [63:0] wd, input logic [63:0] er, input logic ee,
                         input int el, input bit push);
        int k = 0;
        @(negedge clk);
        while (!req_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!req_ready) begin
            chk({name, "_req_ready_timeout"}, 64'd0, 64'd1);
            return;
        end
        req_op = op; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        if (push) sb.push_back('{er, ee, el, cyc, name});
    endtask

    task automatic wait_done(input string name);
        int k = 0;
        while (sb.size() != 0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (sb.size() != 0) begin
            chk({name, "_rsp_timeout"}, 64'd0, 64'd1);
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic req(input string name, input logic [5:0] op, input logic [8:0] addr,
                       input logic [63:0] wd, input logic [63:0] er, input logic ee,
                       input int el, input int exp_pulses);
        int p0;
        p0 = pulse_cnt;
        issue(name, op, addr, wd, er, ee, el, 1'b1);
        wait_done(name);
        chk({name, "_pulses"}, 64'(pulse_cnt - p0), 64'(exp_pulses));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int e0;
        int k;
        repeat (3) @(negedge clk);
        chk("reset_req_ready", {63'd0, req_ready}, 64'd1);
        chk("reset_outputs", {ram_enable, rsp_valid, rsp_err, 61'd0}, 64'd0);
        chk("reset_ram_pins", {23'd0, ram_address, ram_datain}, 64'd0);
        chk("reset_ram_opcode_rdata", {58'd0, ram_opcode} | rsp_rdata, 64'd0);
        reset = 1'b0;
        ram_clr = 1'b0;
        @(negedge clk);

        // Single-byte and word accesses, RAM answering immediately.
        req("SB_0",   OP_SB,  9'd0,  64'h0000_00AA, 64'h0, 1'b0, 4, 1);
        chk("mem0", {56'd0, mem[0]}, 64'hAA);
        req("LB_0",   OP_LB,  9'd0,  64'h0, 64'h00000000_FFFFFFAA, 1'b0, 4, 1);
        req("LBU_0",  OP_LBU, 9'd0,  64'h0, 64'h00000000_000000AA, 1'b0, 4, 1);
        req("SW_8",   OP_SW,  9'd8,  64'hAAFF_AAFF, 64'h0, 1'b0, 4, 1);
        chk("mem8_11", {32'd0, rd_word(9'd8)}, 64'hAAFFAAFF);
        req("LW_8",   OP_LW,  9'd8,  64'h0, 64'h00000000_AAFFAAFF, 1'b0, 4, 1);
        req("LH_8",   OP_LH,  9'd8,  64'h0, 64'h00000000_FFFFAAFF, 1'b0, 4, 1);
        req("LHU_10", OP_LHU, 9'd10, 64'h0, 64'h00000000_0000AAFF, 1'b0, 4, 1);

        // Double-word: two pulses, first word in the upper half.
        req("SD_16", OP_SD, 9'd16, 64'h11223344_55667788, 64'h0, 1'b0, 6, 2);
        chk("mem16_23", {rd_word(9'd16), rd_word(9'd20)}, 64'h11223344_55667788);
        chk("almostdone_after_SD", {63'd0, ram_almostdone}, 64'd0);
        req("LD_16", OP_LD, 9'd16, 64'h0, 64'h11223344_55667788, 1'b0, 6, 2);
        chk("almostdone_after_LD", {63'd0, ram_almostdone}, 64'd0);

        // Rejected at accept: never touch the RAM.
        req("LH_3_misaligned", OP_LH, 9'd3, 64'h0, 64'h0, 1'b1, 1, 0);
        req("illegal_op",      6'b000000, 9'd0, 64'h0, 64'h0, 1'b1, 1, 0);
        req("LW_2_misaligned", OP_LW, 9'd2, 64'h0, 64'h0, 1'b1, 1, 0);
        req("SD_4_misaligned", OP_SD, 9'd4, 64'h0, 64'h0, 1'b1, 1, 0);
        req("LB_511",          OP_LB, 9'd511, 64'h0, 64'h0, 1'b0, 4, 1);

        // Timeout: 16 PULSE cycles, then Enable falls in RECOVER.
        stub_no_done = 1'b1;
        e0 = en_cyc;
        req("LW_timeout", OP_LW, 9'd8, 64'h0, 64'h0, 1'b1, 19, 1);
        chk("timeout_enable_cycles", 64'(en_cyc - e0), 64'd16);
        chk("timeout_enable_low", {63'd0, ram_enable}, 64'd0);
        stub_no_done = 1'b0;

        // Reset during the second pulse of SD leaves the RAM mid-sequence.
        p0 = pulse_cnt;
        issue("SD_24_reset", OP_SD, 9'd24, 64'hCAFEF00D_DEADBEEF, 64'h0, 1'b0, 0, 1'b0);
        k = 0;
        while (!(pulse_cnt == p0 + 1 && !ram_enable) && k < 20) begin
            @(negedge clk);
            k++;
        end
        stub_no_done = 1'b1;
        k = 0;
        while (!ram_enable && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("SD_phase1_pulse", {63'd0, ram_enable}, 64'd1);
        reset = 1'b1;
        #1;
        chk("reset_drops_enable", {63'd0, ram_enable}, 64'd0);
        chk("reset_req_ready_async", {63'd0, req_ready}, 64'd1);
        chk("ram_left_almostdone", {63'd0, ram_almostdone}, 64'd1);
        @(negedge clk);
        reset = 1'b0;
        stub_no_done = 1'b0;
        chk("SD_phase0_written", {32'd0, rd_word(9'd24)}, 64'hCAFEF00D);
        req("LD_after_abort", OP_LD, 9'd16, 64'h0, 64'h0, 1'b1, 2, 0);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_access_initiator.md
Name: mem_access_initiator

Overview:
- Requester-side controller for the ram512x8 byte-addressed, big-endian data memory.
- Accepts one CPU load/store request, validates it, and drives the RAM's Enable/Address/DataIn/opcode pins.
- Waits for the RAM's done signal and sequences double-word accesses as two Enable pulses, checked against almostdone.
- Returns read data or an error to the CPU pipeline's memory stage.

Parameters:
- TIMEOUT, 16: maximum number of PULSE cycles to wait for ram_done before the access is aborted with an error.
- ADDR_W, 9: byte address width (512-byte RAM).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  CPU request strobe.
- req_ready  out  1  high only in IDLE; a request is accepted on a clk edge when req_valid and req_ready are both high.
- req_op  in  6  opcode: SB 101000, SH 101001, SW 101011, SD 111101, LB 100000, LH 100001, LW 100011, LBU 100100, LHU 100101, LD 110101.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  64  store data; single stores use [31:0], SD sends [63:32] first.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  64  load data; single loads in [31:0] with [63:32]=0; LD returns first word in [63:32].
- rsp_err  out  1  qualifies rsp_valid: illegal opcode, misaligned address, timeout, or protocol fault.
- ram_enable  out  1  to RAM Enable.
- ram_address  out  ADDR_W  to RAM Address.
- ram_datain  out  32  to RAM DataIn.
- ram_opcode  out  6  to RAM opcode.
- ram_dataout  in  32  from RAM DataOut.
- ram_done  in  1  from RAM done.
- ram_almostdone  in  1  from RAM almostdone.

Behaviour:
- Reset state, forced immediately on reset assertion regardless of state:
  - state=IDLE, phase=0.
  - ram_enable=0; ram_address, ram_datain, ram_opcode = 0.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0.
- All outputs are registered except req_ready, which is decoded as (state==IDLE).
- Alignment rules:
  - Halfword ops require addr[0]=0.
  - Word ops require addr[1:0]=0.
  - Double-word ops require addr[2:0]=0.
  - No access may therefore cross address 511.
- IDLE:
  - On accept, latch op, addr and wdata.
  - Illegal or misaligned request → RESP with err=1; the RAM is never pulsed.
  - Legal request → load ram_address and ram_opcode, set ram_datain (SD: wdata[63:32], others: wdata[31:0]), go to SETUP.
- SETUP (1 cycle):
  - ram_enable=0 and the RAM pins are stable for the full cycle.
  - A double-word op seen with ram_almostdone=1 (RAM left mid-sequence) → RESP with err=1, no pulse.
  - Otherwise → PULSE, clear the timeout counter.
- PULSE:
  - ram_enable=1.
  - Sampling ram_done=1 on a clk edge captures ram_dataout: into [31:0] for single ops, into [63:32] when phase=0 of LD, into [31:0] when phase=1. Then → RECOVER.
  - Otherwise the counter increments; reaching TIMEOUT → err=1, → RECOVER.
- RECOVER (1 cycle):
  - ram_enable=0, which guarantees a falling edge between pulses.
  - Double op, phase=0, no error: require ram_almostdone=1, else err=1 → RESP.
  - On success set phase=1, drive ram_datain=wdata[31:0] (address and opcode unchanged; the RAM applies the +4 offset itself), → PULSE.
  - All other cases → RESP.
- RESP:
  - rsp_valid=1 for exactly one cycle with rsp_rdata and rsp_err.
  - → IDLE, clearing phase and err.
  - rsp_rdata holds its value until the next response.
- Latency from accept edge to rsp_valid:
  - Single access: 4 cycles when the RAM responds immediately.
  - Double access: 6 cycles.
  - Error detected at accept: 1 cycle.
- req_valid while busy is ignored; there is no queuing.
- Sign/zero extension is performed by the RAM; the initiator passes data through unmodified.
- Reset during PULSE drops ram_enable the same instant. The RAM may keep almostdone=1, which the next double op detects in SETUP.

Decomposition:
- Shared package mem_pkg holds:
  - Opcode localparams (OP_SB … OP_LD).
  - State encoding: IDLE, SETUP, PULSE, RECOVER, RESP.
  - Size encoding: BYTE, HALF, WORD, DOUBLE.
- Sub-module mem_op_decode (combinational): takes op and addr[2:0], returns legal, is_store, is_double and aligned.
- The FSM, timeout counter and data capture remain in mem_access_initiator.

Test Plan:
- SB addr 0, wdata 0xAA, then LB addr 0 → RAM Mem[0]=0xAA; rsp_rdata=0x00000000_FFFFFFAA, err=0; each rsp_valid 4 cycles after accept.
- SW addr 8, wdata 0xAAFFAAFF, then LW addr 8 → rsp_rdata[31:0]=0xAAFFAAFF; Mem[8..11]=AA,FF,AA,FF.
- SD addr 16, wdata 0x11223344_55667788, then LD addr 16 → two Enable pulses each; Mem[16..23]=11..88; rsp_rdata=0x1122334455667788 at 6 cycles; ram_almostdone ends 0.
- LH addr 3 and illegal op 6'b000000 → rsp_valid 1 cycle after accept, err=1, ram_enable never rises.
- ram_done stubbed low → err=1 after TIMEOUT=16 PULSE cycles; ram_enable falls in RECOVER.
- Assert reset in PULSE of SD phase 1 → ram_enable=0 immediately, req_ready=1 after release; following LD with stubbed ram_almostdone=1 → err=1, no pulse.
